// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller.
// - fetch_state_e : controller FSM states (IDLE, RUN, HALT)
// - IMEM_DEPTH    : default instruction memory size in words
// - NOP_INSTR     : instruction word loaded into IF/ID on a flush
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int          IMEM_DEPTH = 8;
    localparam logic [31:0] NOP_INSTR  = 32'h0;

endpackage

// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller and its environment
// (hazard unit, EX-stage branch resolution, instruction memory, ID stage).
// - stall_i, redirect_i, redirect_pc_i : pipeline control into fetch
// - imem_addr_o / imem_instr_i         : instruction memory read port
// - if_valid_o, if_pc_o, if_instr_o    : IF/ID register contents
// - halted_o, fetch_count_o            : status
// modport master : the fetch controller side
// modport slave  : the environment side
interface fetch_controller_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) ();

    logic             stall_i;
    logic             redirect_i;
    logic [PC_W-1:0]  redirect_pc_i;
    logic [PC_W-1:0]  imem_addr_o;
    logic [31:0]      imem_instr_i;
    logic             if_valid_o;
    logic [PC_W-1:0]  if_pc_o;
    logic [31:0]      if_instr_o;
    logic             halted_o;
    logic [CNT_W-1:0] fetch_count_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_instr_i,
        output imem_addr_o, if_valid_o, if_pc_o, if_instr_o, halted_o, fetch_count_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_instr_i,
        input  imem_addr_o, if_valid_o, if_pc_o, if_instr_o, halted_o, fetch_count_o
    );

endinterface

// File: rtl/fetch_controller_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Ports: clk, rst (synchronous, active-low), inc, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for a 5-stage MIPS pipeline.
// Owns the word-indexed PC, drives the instruction memory address and loads
// the IF/ID register. Fetch stops (HALT) once the PC leaves 0..DEPTH-1.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : fetch_controller_if.master (control in, imem port, IF/ID out, status)
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_controller_if.master  bus
);

    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(DEPTH);

    fetch_state_e    state_q,    state_d;
    logic [PC_W-1:0] pc_q,       pc_d;
    logic            if_valid_q, if_valid_d;
    logic [PC_W-1:0] if_pc_q,    if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic            halted_q,   halted_d;
    logic            fetch_inc;
    logic [PC_W-1:0] pc_next;
    logic            target_in_range;

    assign pc_next         = pc_q + PC_W'(1);
    assign target_in_range = (bus.redirect_pc_i < DEPTH_PC);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        fetch_inc  = 1'b0;

        case (state_q)
            // One dead cycle after reset; control inputs are not looked at.
            ST_IDLE: state_d = ST_RUN;

            ST_RUN: begin
                if (bus.redirect_i) begin
                    // Redirect wins over stall: the wrong-path entry is squashed.
                    pc_d       = bus.redirect_pc_i;
                    if_valid_d = 1'b0;
                    if_pc_d    = '0;
                    if_instr_d = NOP_INSTR;
                    if (!target_in_range) begin
                        state_d = ST_HALT;
                    end
                end else if (!bus.stall_i) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = bus.imem_instr_i;
                    fetch_inc  = 1'b1;
                    pc_d       = pc_next;
                    if (pc_next == DEPTH_PC) begin
                        state_d = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                if (bus.redirect_i && target_in_range) begin
                    pc_d       = bus.redirect_pc_i;
                    if_valid_d = 1'b0;
                    if_pc_d    = '0;
                    if_instr_d = NOP_INSTR;
                    state_d    = ST_RUN;
                end else if (!bus.stall_i) begin
                    // A stalled ID stage still needs the last instruction, so
                    // the entry is only dropped once the stall lifts.
                    if_valid_d = 1'b0;
                    if_pc_d    = '0;
                    if_instr_d = NOP_INSTR;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Registered so halted_o lines up with the state it decodes.
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            halted_q   <= halted_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_fetch_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (fetch_inc),
        .count (bus.fetch_count_o)
    );

    assign bus.imem_addr_o = pc_q;
    assign bus.if_valid_o  = if_valid_q;
    assign bus.if_pc_o     = if_pc_q;
    assign bus.if_instr_o  = if_instr_q;
    assign bus.halted_o    = halted_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: two instances (CNT_W=16 and CNT_W=3) driven by
// the same stimulus, an 8-word program memory, and a cycle-level model of
// the fetch rules that every output is compared against after each edge.
module tb_fetch_controller;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;

    always #5 clk = ~clk;

    fetch_controller_if #(.PC_W(32), .CNT_W(16)) bus_a ();
    fetch_controller_if #(.PC_W(32), .CNT_W(3))  bus_b ();

    fetch_controller #(.PC_W(32), .DEPTH(DEPTH), .CNT_W(16)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.master)
    );
    fetch_controller #(.PC_W(32), .DEPTH(DEPTH), .CNT_W(3)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.master)
    );

    function automatic logic [31:0] prog(input logic [31:0] a);
        case (a)
            32'd0:   prog = 32'h04430800;
            32'd1:   prog = 32'h8C010004;
            32'd2:   prog = 32'h00221820;
            32'd3:   prog = 32'hAC030008;
            32'd4:   prog = 32'h10000002;
            32'd5:   prog = 32'h20420001;
            32'd6:   prog = 32'h08000000;
            32'd7:   prog = 32'h3C05ABCD;
            default: prog = 32'h0;
        endcase
    endfunction

    assign bus_a.stall_i       = stall;
    assign bus_a.redirect_i    = redirect;
    assign bus_a.redirect_pc_i = rpc;
    assign bus_a.imem_instr_i  = prog(bus_a.imem_addr_o);
    assign bus_b.stall_i       = stall;
    assign bus_b.redirect_i    = redirect;
    assign bus_b.redirect_pc_i = rpc;
    assign bus_b.imem_instr_i  = prog(bus_b.imem_addr_o);

    // Model state
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    int          m_state;
    int          m_pc;
    bit          m_v;
    int          m_ip;
    logic [31:0] m_ii;
    int          m_cnt_a;
    int          m_cnt_b;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_flush();
        m_v  = 1'b0;
        m_ip = 0;
        m_ii = 32'h0;
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_state = M_IDLE; m_pc = 0; m_flush(); m_cnt_a = 0; m_cnt_b = 0;
        end else if (m_state == M_IDLE) begin
            m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (redirect) begin
                m_pc = int'(rpc);
                m_flush();
                if (rpc >= DEPTH) m_state = M_HALT;
            end else if (!stall) begin
                m_v  = 1'b1;
                m_ip = m_pc;
                m_ii = prog(32'(m_pc));
                if (m_cnt_a < 65535) m_cnt_a++;
                if (m_cnt_b < 7) m_cnt_b++;
                m_pc++;
                if (m_pc == DEPTH) m_state = M_HALT;
            end
        end else begin
            if (redirect && rpc < DEPTH) begin
                m_pc = int'(rpc);
                m_flush();
                m_state = M_RUN;
            end else if (!stall) begin
                m_flush();
            end
        end
    endtask

    task automatic compare_all();
        chk("a.imem_addr", 64'(bus_a.imem_addr_o), 64'(m_pc));
        chk("a.if_valid",  64'(bus_a.if_valid_o),  64'(m_v));
        chk("a.if_pc",     64'(bus_a.if_pc_o),     64'(m_ip));
        chk("a.if_instr",  64'(bus_a.if_instr_o),  64'(m_ii));
        chk("a.halted",    64'(bus_a.halted_o),    64'(m_state == M_HALT));
        chk("a.count",     64'(bus_a.fetch_count_o), 64'(m_cnt_a));
        chk("b.imem_addr", 64'(bus_b.imem_addr_o), 64'(m_pc));
        chk("b.if_valid",  64'(bus_b.if_valid_o),  64'(m_v));
        chk("b.if_pc",     64'(bus_b.if_pc_o),     64'(m_ip));
        chk("b.if_instr",  64'(bus_b.if_instr_o),  64'(m_ii));
        chk("b.halted",    64'(bus_b.halted_o),    64'(m_state == M_HALT));
        chk("b.count",     64'(bus_b.fetch_count_o), 64'(m_cnt_b));
    endtask

    // One clock: model advances on the same edge as the DUT, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Reset then the single IDLE cycle; leaves the controller in RUN at pc=0.
    task automatic restart();
        stall = 1'b0; redirect = 1'b0; rpc = 32'd0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        stall = 1'b0; redirect = 1'b0; rpc = 32'd0; rst = 1'b0;

        // Reset and free run through the program
        step();
        chk("rst.if_valid", 64'(bus_a.if_valid_o), 64'd0);
        chk("rst.count",    64'(bus_a.fetch_count_o), 64'd0);
        chk("rst.halted",   64'(bus_a.halted_o), 64'd0);
        rst = 1'b1;
        step();
        chk("idle.if_valid", 64'(bus_a.if_valid_o), 64'd0);
        step();
        chk("first.if_pc",    64'(bus_a.if_pc_o), 64'd0);
        chk("first.if_instr", 64'(bus_a.if_instr_o), 64'h04430800);
        repeat (7) step();
        chk("run.last_pc", 64'(bus_a.if_pc_o), 64'd7);
        chk("run.halted",  64'(bus_a.halted_o), 64'd1);
        chk("run.count",   64'(bus_a.fetch_count_o), 64'd8);
        step();
        chk("halt.flush", 64'(bus_a.if_valid_o), 64'd0);

        // Stall at pc=3
        restart();
        repeat (3) step();
        stall = 1'b1;
        repeat (3) step();
        chk("stall.if_pc", 64'(bus_a.if_pc_o), 64'd2);
        chk("stall.addr",  64'(bus_a.imem_addr_o), 64'd3);
        chk("stall.count", 64'(bus_a.fetch_count_o), 64'd3);
        stall = 1'b0;
        step();
        chk("unstall.pc3", 64'(bus_a.if_pc_o), 64'd3);
        step();
        chk("unstall.pc4", 64'(bus_a.if_pc_o), 64'd4);

        // Redirect beats stall, then HALT redirects
        restart();
        repeat (2) step();
        redirect = 1'b1; rpc = 32'd6; stall = 1'b1;
        step();
        chk("redir.valid", 64'(bus_a.if_valid_o), 64'd0);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk("redir.pc6", 64'(bus_a.if_pc_o), 64'd6);
        step();
        chk("redir.pc7",    64'(bus_a.if_pc_o), 64'd7);
        chk("redir.halted", 64'(bus_a.halted_o), 64'd1);
        redirect = 1'b1; rpc = 32'd9;
        step();
        chk("halt.ignore9", 64'(bus_a.halted_o), 64'd1);
        rpc = 32'd1;
        step();
        chk("halt.resume", 64'(bus_a.halted_o), 64'd0);
        redirect = 1'b0;
        step();
        chk("resume.pc1", 64'(bus_a.if_pc_o), 64'd1);

        // Three programs back to back: 3-bit counter saturates
        restart();
        for (int p = 0; p < 3; p++) begin
            repeat (8) step();
            redirect = 1'b1; rpc = 32'd0;
            step();
            redirect = 1'b0;
        end
        chk("sat.count_b", 64'(bus_b.fetch_count_o), 64'd7);
        chk("sat.count_a", 64'(bus_a.fetch_count_o), 64'd24);

        // Reset during a stall at pc=5, redirect ignored in IDLE
        restart();
        repeat (5) step();
        stall = 1'b1; rst = 1'b0;
        step();
        chk("mrst.valid",  64'(bus_a.if_valid_o), 64'd0);
        chk("mrst.addr",   64'(bus_a.imem_addr_o), 64'd0);
        chk("mrst.count",  64'(bus_a.fetch_count_o), 64'd0);
        chk("mrst.instr",  64'(bus_a.if_instr_o), 64'd0);
        rst = 1'b1; stall = 1'b0; redirect = 1'b1; rpc = 32'd9;
        step();
        chk("idle.noredir", 64'(bus_a.halted_o), 64'd0);
        // Out-of-range redirect from RUN halts
        step();
        chk("run.redir9", 64'(bus_a.halted_o), 64'd1);
        redirect = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
